// File: rtl/shift_window_pkg.sv
// Shared types and geometry helpers for the shift-register window controller.
// tap_index/buf_len describe how a K x K window maps onto the tapped line buffer.
package shift_window_pkg;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Store index 0 is the newest pixel, so the window's top-left tap is the oldest one.
    function automatic int tap_index(input int i, input int j, input int w, input int k);
        return (k - 1 - i) * w + (k - 1 - j);
    endfunction

    function automatic int buf_len(input int w, input int k);
        return (k - 1) * w + k;
    endfunction

endpackage

// File: rtl/window_pos_counter.sv
// Raster position tracker: column/row counters with frame wrap, plus flags telling
// whether the current position completes a window and whether it closes the frame.
module window_pos_counter #(
    parameter int ImgWidth  = 28,
    parameter int ImgHeight = 28,
    parameter int Kernel    = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         advance,
    input  logic                         resync,
    output logic [$clog2(ImgWidth)-1:0]  col,
    output logic [$clog2(ImgHeight)-1:0] row,
    output logic                         qualify,
    output logic                         frame_end
);

    localparam int CW = $clog2(ImgWidth);
    localparam int RW = $clog2(ImgHeight);

    localparam logic [CW-1:0] ColMax   = CW'(ImgWidth - 1);
    localparam logic [RW-1:0] RowMax   = RW'(ImgHeight - 1);
    localparam logic [CW-1:0] FirstCol = CW'(Kernel - 1);
    localparam logic [RW-1:0] FirstRow = RW'(Kernel - 1);

    assign qualify   = (row >= FirstRow) && (col >= FirstCol);
    assign frame_end = (row == RowMax) && (col == ColMax);

    // A resync (early frame end) restarts the raster exactly like a natural wrap.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (resync || frame_end) begin
                col <= '0;
                row <= '0;
            end else if (col == ColMax) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/shift_window_ctrl.sv
// Stream controller feeding the tapped line buffer and handing complete K x K windows
// downstream. Optional frame-end checking is enabled by SHIFT_WINDOW_CTRL_LAST_CHK_EN.
module shift_window_ctrl
    import shift_window_pkg::*;
#(
    parameter int N         = 8,
    parameter int ImgWidth  = 28,
    parameter int ImgHeight = 28,
    parameter int Kernel    = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         pix_valid_i,
    output logic                         pix_ready_o,
    input  logic [N-1:0]                 pix_data_i,
    input  logic                         pix_last_i,
    output logic                         shift_en_o,
    output logic [N-1:0]                 shift_data_o,
    output logic                         win_valid_o,
    input  logic                         win_ready_i,
    output logic [$clog2(ImgHeight)-1:0] win_row_o,
    output logic [$clog2(ImgWidth)-1:0]  win_col_o,
    output logic                         frame_done_o,
    output logic                         err_o
);

    localparam int CW = $clog2(ImgWidth);
    localparam int RW = $clog2(ImgHeight);

    localparam logic [CW-1:0] WinOffCol = CW'(Kernel - 1);
    localparam logic [RW-1:0] WinOffRow = RW'(Kernel - 1);

    logic          acc;
    logic          qualify;
    logic          frame_end;
    logic          early_last;
    logic          wrap;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          win_valid_q;
    logic [RW-1:0] win_row_q;
    logic [CW-1:0] win_col_q;
    logic          frame_done_q;
    state_e        state_q;
    state_e        state_d;

    // The buffer may only shift when the window it holds has been taken or none is pending.
    assign pix_ready_o  = ~win_valid_q | win_ready_i;
    assign acc          = pix_valid_i & pix_ready_o;
    assign shift_en_o   = acc;
    assign shift_data_o = pix_data_i;
    assign wrap         = acc & (frame_end | early_last);

    window_pos_counter #(
        .ImgWidth (ImgWidth),
        .ImgHeight(ImgHeight),
        .Kernel   (Kernel)
    ) u_pos (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .advance  (acc),
        .resync   (early_last),
        .col      (col),
        .row      (row),
        .qualify  (qualify),
        .frame_end(frame_end)
    );

`ifdef SHIFT_WINDOW_CTRL_LAST_CHK_EN
    logic last_err;
    logic err_q;

    assign early_last = acc & pix_last_i & ~frame_end;
    assign last_err   = acc & (pix_last_i ^ frame_end);
    assign err_o      = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (last_err) begin
            err_q <= 1'b1;
        end
    end
`else
    // The frame-end marker carries no meaning in this build.
    assign early_last = 1'b0;
    assign err_o      = pix_last_i & 1'b0;
`endif

    // A qualifying accept reloads the window even on the edge that consumes the old one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
        end else if (acc && qualify) begin
            win_valid_q <= 1'b1;
            win_row_q   <= row - WinOffRow;
            win_col_q   <= col - WinOffCol;
        end else if (win_ready_i) begin
            win_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= acc & ((qualify & frame_end) | early_last);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: begin
                if (!wrap && acc && qualify) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (wrap) begin
                    state_d = ST_FILL;
                end else if (win_valid_q && !win_ready_i) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (win_ready_i) begin
                    state_d = wrap ? ST_FILL : ST_RUN;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    assign win_valid_o  = win_valid_q;
    assign win_row_o    = win_row_q;
    assign win_col_o    = win_col_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: doc/shift_window_ctrl.md
# shift_window_ctrl

Stream controller that sits directly upstream of the tapped shift-register line buffer in the convolution path. It accepts a raster-ordered pixel stream, drives the buffer's shift enable and data input, and tracks row and column position. Whenever the buffer's taps hold a complete K×K window, it raises a window-valid handshake to the downstream MAC stage and stalls input until that window is consumed.

## Interface
- N, 8, pixel width
- ImgWidth, 28, pixels per row (W)
- ImgHeight, 28, rows per frame (H)
- Kernel, 3, window side K; requires 2 ≤ K ≤ min(W, H)
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- pix_valid_i  in  1  input pixel valid
- pix_ready_o  out  1  input pixel accepted when valid & ready
- pix_data_i  in  N  input pixel
- pix_last_i  in  1  frame-end marker, qualified by the input handshake
- shift_en_o  out  1  buffer shift enable
- shift_data_o  out  N  buffer data input
- win_valid_o  out  1  buffer taps hold a complete window
- win_ready_i  in  1  downstream has consumed the window
- win_row_o  out  $clog2(H)  window top-left row
- win_col_o  out  $clog2(W)  window top-left column
- frame_done_o  out  1  one-cycle pulse, set with the frame's last window
- err_o  out  1  sticky frame-framing error

## Operation
- Required buffer length is (K-1)·W + K. Window tap (i,j), with (0,0) as top-left, sits at store index (K-1-i)·W + (K-1-j).
- Accept condition: acc = pix_valid_i & pix_ready_o.
  - shift_en_o = acc, combinational.
  - shift_data_o = pix_data_i, combinational.
- pix_ready_o = !win_valid_o | win_ready_i. The window held in the buffer never shifts before it is consumed.
- Counters col (0..W-1) and row (0..H-1) advance on acc.
  - col wraps to 0 after W-1, and row increments.
  - After pixel (H-1, W-1), both wrap to 0.
- When an accepted pixel is at (r,c) with r ≥ K-1 and c ≥ K-1, the next cycle shows:
  - win_valid_o = 1,
  - win_row_o = r-K+1,
  - win_col_o = c-K+1.
- Pixels at c < K-1 shift in but raise no window. These are the row-straddling positions.
- Windows per frame: (H-K+1)·(W-K+1). The default configuration gives 676.
- win_valid_o and win_row_o/win_col_o hold until the cycle with win_ready_i = 1. On that edge:
  - the window clears, unless the same edge accepts a new qualifying pixel;
  - a new qualifying pixel reloads the window the next cycle.
- frame_done_o pulses for one cycle, coincident with the first cycle win_valid_o shows the window at (H-K, W-K).
- State machine, in a shared state register:
  - FILL: row < K-1, or row = K-1 and col < K-1.
  - RUN: window positions reachable.
  - HOLD: win_valid_o & !win_ready_i.
  - Transitions: FILL→RUN on the first qualifying accept; RUN↔HOLD on the stall condition; RUN→FILL on the frame wrap.
- Reset: clears counters, win_valid_o, frame_done_o and err_o, and puts the block in FILL. After reset, pix_ready_o = 1.
- Mid-frame reset drops the partial frame. The buffer shares rst_i, so its contents clear too.

## Timing
- Pixel to buffer: zero cycles. It is in the store on the accept edge.
- Accept of a qualifying pixel → win_valid_o: exactly one cycle.
- Sustained throughput: 1 pixel/cycle while win_ready_i = 1 permanently.
- Backpressure: if win_ready_i = 0 with a window pending, pix_ready_o = 0 in the same cycle (combinational).

## Configuration
- SHIFT_WINDOW_CTRL_LAST_CHK_EN defined:
  - pix_last_i is checked on every acc.
  - err_o sets, and stays set until reset, when pix_last_i = 1 at a position other than (H-1, W-1), or pix_last_i = 0 at (H-1, W-1).
  - An early last also forces both counters to 0 on that edge (resync) and pulses frame_done_o.
- Undefined:
  - pix_last_i is ignored and err_o is tied to 0.
  - The port list is identical in both builds.

## Structure
- Package shift_window_pkg:
  - state enum (FILL, RUN, HOLD);
  - function tap_index(i, j, W, K);
  - function buf_len(W, K).
- Sub-module window_pos_counter: col/row counters with wrap, a qualify flag and a frame-end flag. It is instantiated once.

## Test plan
Parameters for all scenarios: W=5, H=4, K=3, buffer length 13.
- Stream 20 pixels with values 0..19 and win_ready_i = 1 → 6 windows.
  - Positions (0,0), (0,1), (0,2), (1,0), (1,1), (1,2).
  - Each window appears one cycle after pixels 12, 13, 14, 17, 18, 19.
  - frame_done_o pulses with (1,2).
  - Tap(0,0) of the first window reads value 0.
- Hold win_ready_i = 0 for 4 cycles after the first window → pix_ready_o = 0, no shift_en_o, and win_row_o/win_col_o stable at (0,0). Release → resume with no lost pixel.
- Send two back-to-back frames → the second frame's first window comes after pixel 12 of frame 2, and its counters restart from 0.
- Assert rst_i mid-frame after pixel 13 → all outputs clear immediately. The next frame produces the correct 6 windows.
- With LAST_CHK_EN defined, send pix_last_i on pixel 10 → err_o = 1 and stays set, and the counters resync to 0.
- With LAST_CHK_EN defined, a frame with no pix_last_i on pixel 19 → err_o = 1. Without the macro, the same stimuli leave err_o = 0.
